// File: rtl/b_stage_param.sv
// Branch stage: merges a per-destination flag from a writable table into each
// accepted packet and steers the held result to channel a or b.
module b_stage_param #(
   parameter int PW      = 38,
   parameter int DEST_LO = 20,
   parameter int DEST_W  = 7,
   parameter int BR_POS  = 18,
   parameter int MF_POS  = 18,
   parameter int CNT_W   = 16
) (
   input  logic              CP,
   input  logic              MR,
   input  logic [PW-1:0]     PACKET_IN,
   input  logic              Send_in,
   output logic              Ack_out,
   output logic [PW-1:0]     PACKET_OUT,
   output logic              Send_out_a,
   input  logic              Ack_in_a,
   output logic              Send_out_b,
   input  logic              Ack_in_b,
   input  logic              Tw_en,
   input  logic [DEST_W-1:0] Tw_addr,
   input  logic              Tw_data,
   output logic [CNT_W-1:0]  Cnt_a,
   output logic [CNT_W-1:0]  Cnt_b
);

   localparam int DEPTH = 1 << DEST_W;

   logic [PW-1:0]     dl;
   logic              v;
   logic              s;
   logic [DEPTH-1:0]  sub_ps;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;

   logic [DEST_W-1:0] dest;
   logic              flag;
   logic [PW-1:0]     merged;
   logic              sel_ack;
   logic              in_xfer;
   logic              out_a;
   logic              out_b;

   // A write to the entry being looked up on the same edge is forwarded.
   always_comb begin
      dest           = PACKET_IN[DEST_LO +: DEST_W];
      flag           = (Tw_en && (Tw_addr == dest)) ? Tw_data : sub_ps[dest];
      merged         = PACKET_IN;
      merged[MF_POS] = flag;
      sel_ack        = s ? Ack_in_b : Ack_in_a;
      Ack_out        = !MR && (!v || sel_ack);
      in_xfer        = Send_in && Ack_out;
      out_a          = v && !s && Ack_in_a;
      out_b          = v && s && Ack_in_b;
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         dl     <= '0;
         v      <= 1'b0;
         s      <= 1'b0;
         sub_ps <= '0;
         cnt_a  <= '0;
         cnt_b  <= '0;
      end else begin
         // Routing uses the original branch bit, even when it is the merge target.
         if (in_xfer) begin
            dl <= merged;
            s  <= PACKET_IN[BR_POS];
            v  <= 1'b1;
         end else if (out_a || out_b) begin
            v  <= 1'b0;
         end
         if (Tw_en) sub_ps[Tw_addr] <= Tw_data;
         if (out_a) cnt_a <= cnt_a + CNT_W'(1);
         if (out_b) cnt_b <= cnt_b + CNT_W'(1);
      end
   end

   assign PACKET_OUT = dl;
   assign Send_out_a = v && !s;
   assign Send_out_b = v && s;
   assign Cnt_a      = cnt_a;
   assign Cnt_b      = cnt_b;

endmodule

// File: tb/tb_b_stage_param.sv
// Bench for b_stage_param: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a transaction model.
module tb_b_stage_param;

   logic        cp = 1'b0;
   logic        mr, send_in, ack_in_a, ack_in_b, tw_en, tw_data;
   logic [37:0] packet_in;
   logic [6:0]  tw_addr;
   logic        ack_out, send_out_a, send_out_b;
   logic [37:0] packet_out;
   logic [3:0]  cnt_a, cnt_b;

   int errors = 0;
   int checks = 0;

   always #5 cp = ~cp;

   b_stage_param #(.CNT_W(4)) dut (
      .CP(cp), .MR(mr), .PACKET_IN(packet_in), .Send_in(send_in), .Ack_out(ack_out),
      .PACKET_OUT(packet_out), .Send_out_a(send_out_a), .Ack_in_a(ack_in_a),
      .Send_out_b(send_out_b), .Ack_in_b(ack_in_b), .Tw_en(tw_en), .Tw_addr(tw_addr),
      .Tw_data(tw_data), .Cnt_a(cnt_a), .Cnt_b(cnt_b)
   );

   // Transaction-level reference: one held packet, its channel, a flag table, counts.
   logic        m_v, m_s;
   logic [37:0] m_pkt;
   bit          m_tbl[128];
   int          m_ca, m_cb;

   function automatic logic [37:0] mk(logic [6:0] dest, logic b);
      return {1'b1, 10'b0, dest, 1'b0, b, 18'h00ABC};
   endfunction

   function automatic logic m_ack_f();
      return !mr && (!m_v || (m_s ? ack_in_b : ack_in_a));
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, ".ack_out"}, 64'(ack_out), 64'(m_ack_f()));
      chk({tag, ".send_a"}, 64'(send_out_a), 64'(m_v && !m_s));
      chk({tag, ".send_b"}, 64'(send_out_b), 64'(m_v && m_s));
      chk({tag, ".packet"}, 64'(packet_out), 64'(m_pkt));
      chk({tag, ".cnt_a"}, 64'(cnt_a), 64'(m_ca));
      chk({tag, ".cnt_b"}, 64'(cnt_b), 64'(m_cb));
   endtask

   task automatic model_update();
      logic       acc, deliv, f;
      logic [6:0] d;
      if (mr) begin
         m_v = 0; m_s = 0; m_pkt = '0; m_ca = 0; m_cb = 0;
         foreach (m_tbl[i]) m_tbl[i] = 0;
      end else begin
         acc   = send_in && m_ack_f();
         deliv = m_v && (m_s ? ack_in_b : ack_in_a);
         d     = packet_in[26:20];
         f     = (tw_en && tw_addr == d) ? tw_data : m_tbl[d];
         if (deliv) begin
            if (m_s) m_cb = (m_cb + 1) % 16;
            else     m_ca = (m_ca + 1) % 16;
         end
         if (acc) begin
            m_pkt     = packet_in;
            m_pkt[18] = f;
            m_s       = packet_in[18];
            m_v       = 1;
         end else if (deliv) begin
            m_v = 0;
         end
         if (tw_en) m_tbl[tw_addr] = tw_data;
      end
   endtask

   task automatic drive(logic i_mr, logic i_sin, logic [37:0] i_pkt, logic i_aa, logic i_ab,
                        logic i_twe, logic [6:0] i_twa, logic i_twd);
      mr = i_mr; send_in = i_sin; packet_in = i_pkt; ack_in_a = i_aa; ack_in_b = i_ab;
      tw_en = i_twe; tw_addr = i_twa; tw_data = i_twd;
      #1;
   endtask

   task automatic tick();
      @(posedge cp);
      model_update();
      @(negedge cp);
   endtask

   typedef struct {
      logic mr, sin; logic [6:0] dest; logic br, aa, ab, twe; logic [6:0] twa; logic twd;
      logic e_ack, e_sa, e_sb; logic [37:0] e_pkt; logic [3:0] e_ca, e_cb;
   } vec_t;

   function automatic vec_t mkv(logic i_mr, logic i_sin, logic [6:0] i_dest, logic i_br,
                                logic i_aa, logic i_ab, logic i_twe, logic [6:0] i_twa,
                                logic i_twd, logic e_ack, logic e_sa, logic e_sb,
                                logic [37:0] e_pkt, logic [3:0] e_ca, logic [3:0] e_cb);
      vec_t r;
      r.mr = i_mr; r.sin = i_sin; r.dest = i_dest; r.br = i_br; r.aa = i_aa; r.ab = i_ab;
      r.twe = i_twe; r.twa = i_twa; r.twd = i_twd; r.e_ack = e_ack; r.e_sa = e_sa;
      r.e_sb = e_sb; r.e_pkt = e_pkt; r.e_ca = e_ca; r.e_cb = e_cb;
      return r;
   endfunction

   vec_t vecs[14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Expected outputs are those seen during the row's cycle, before its edge.
      vecs[0]  = mkv(1, 1, 3, 0, 1, 0, 0, 0,  0, 0, 0, 0, '0,       0, 0);
      vecs[1]  = mkv(1, 1, 3, 0, 1, 0, 0, 0,  0, 0, 0, 0, '0,       0, 0);
      vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 1, 5,  1, 1, 0, 0, '0,       0, 0);
      vecs[3]  = mkv(0, 1, 5, 0, 1, 0, 0, 0,  0, 1, 0, 0, '0,       0, 0);
      vecs[4]  = mkv(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, mk(5, 1), 0, 0);
      vecs[5]  = mkv(0, 1, 6, 1, 0, 1, 0, 0,  0, 1, 0, 0, mk(5, 1), 1, 0);
      vecs[6]  = mkv(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, mk(6, 0), 1, 0);
      vecs[7]  = mkv(0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 1, mk(6, 0), 1, 0);
      vecs[8]  = mkv(0, 1, 9, 0, 1, 0, 1, 9,  1, 1, 0, 0, mk(6, 0), 1, 1);
      vecs[9]  = mkv(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, mk(9, 1), 1, 1);
      vecs[10] = mkv(1, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, mk(9, 1), 2, 1);
      vecs[11] = mkv(0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, '0,       0, 0);
      vecs[12] = mkv(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, mk(10, 0), 0, 0);
      vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, mk(10, 0), 1, 0);

      drive(1, 0, '0, 0, 0, 0, 0, 0);
      @(negedge cp);
      tick();

      for (int i = 0; i < 14; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         drive(vecs[i].mr, vecs[i].sin, mk(vecs[i].dest, vecs[i].br), vecs[i].aa, vecs[i].ab,
               vecs[i].twe, vecs[i].twa, vecs[i].twd);
         check_model(t);
         chk({t, ".tbl_ack"}, 64'(ack_out), 64'(vecs[i].e_ack));
         chk({t, ".tbl_sa"}, 64'(send_out_a), 64'(vecs[i].e_sa));
         chk({t, ".tbl_sb"}, 64'(send_out_b), 64'(vecs[i].e_sb));
         chk({t, ".tbl_pkt"}, 64'(packet_out), 64'(vecs[i].e_pkt));
         chk({t, ".tbl_ca"}, 64'(cnt_a), 64'(vecs[i].e_ca));
         chk({t, ".tbl_cb"}, 64'(cnt_b), 64'(vecs[i].e_cb));
         tick();
      end

      // Backpressure on channel a with a waiting sender, then streaming.
      drive(0, 1, mk(20, 0), 1, 0, 0, 0, 0);
      check_model("bp_load");
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, mk(21, 0), 0, 1, 0, 0, 0);
         check_model("bp_hold");
         chk("bp_hold.ack_out", 64'(ack_out), 64'(0));
         chk("bp_hold.dl", 64'(packet_out), 64'(mk(20, 0)));
         chk("bp_hold.send_a", 64'(send_out_a), 64'(1));
         tick();
      end
      drive(0, 1, mk(21, 0), 1, 0, 0, 0, 0);
      chk("bp_release.ack_out", 64'(ack_out), 64'(1));
      tick();
      for (int i = 22; i < 26; i++) begin
         drive(0, 1, mk(7'(i), 0), 1, 0, 0, 0, 0);
         check_model("stream");
         chk("stream.pkt", 64'(packet_out), 64'(mk(7'(i - 1), 0)));
         chk("stream.send_a", 64'(send_out_a), 64'(1));
         tick();
      end

      // Counter wrap: 17 deliveries on b.
      drive(1, 0, '0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 18; i++) begin
         drive(0, i < 17, mk(7'(i), 1), 0, 1, 0, 0, 0);
         check_model("wrap");
         tick();
      end
      drive(0, 0, '0, 0, 0, 0, 0, 0);
      chk("wrap.cnt_b", 64'(cnt_b), 64'(1));
      chk("wrap.cnt_a", 64'(cnt_a), 64'(0));

      // Reset while a packet is held.
      drive(0, 1, mk(30, 1), 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, '0, 0, 0, 0, 0, 0);
      chk("mr_mid.send_b_before", 64'(send_out_b), 64'(1));
      tick();
      drive(1, 1, mk(31, 0), 1, 1, 1, 31, 1);
      chk("mr_mid.ack_out", 64'(ack_out), 64'(0));
      tick();
      drive(0, 0, '0, 0, 0, 0, 0, 0);
      check_model("mr_mid");
      chk("mr_mid.send_b", 64'(send_out_b), 64'(0));
      chk("mr_mid.pkt", 64'(packet_out), 64'(0));
      chk("mr_mid.cnt_b", 64'(cnt_b), 64'(0));

      // Randomized traffic with frequent table/lookup collisions.
      for (int i = 0; i < 400; i++) begin
         logic [63:0] r;
         logic [37:0] p;
         r = {$urandom(), $urandom()};
         p = r[37:0];
         p[26:20] = 7'($urandom_range(0, 15));
         drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), p,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         check_model("rand");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
